// File: rtl/rst_sync_stretch.sv
// rst_sync_stretch: reset synchronizer with hold stretch, software reset and release pulse
//   CLK        in   single clock, rising edge
//   RST        in   asynchronous active-low reset
//   SW_RST_REQ in   software reset request, honoured only while running
//   SYNC_RST   out  active-low reset, async assert, sync release
//   RST_DONE   out  one-cycle pulse on each release of SYNC_RST
//   RST_CNT    out  saturating count of accepted software resets
module rst_sync_stretch #(
  parameter int NUM_STAGES  = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SW_RST_REQ,
  output logic                 SYNC_RST,
  output logic                 RST_DONE,
  output logic [CNT_WIDTH-1:0] RST_CNT
);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef enum logic [1:0] {ASSERT, SYNC, HOLD, RUN} state_t;
  state_t state, state_n;
  logic [NUM_STAGES-1:0] chain;
  logic [HW-1:0] hcnt;
  logic accept;
  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("NUM_STAGES must be at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must be at least 1");
  end
  always_comb begin
    state_n = state;
    accept  = state == RUN && SW_RST_REQ;
    // chain[NUM_STAGES-2] high in SYNC means the last stage fills on this edge
    if (accept)
      state_n = ASSERT;
    else if (state == ASSERT)
      state_n = SYNC;
    else if (state == SYNC && chain[NUM_STAGES-2])
      state_n = HOLD_CYCLES == 0 ? RUN : HOLD;
    else if (state == HOLD && 32'(hcnt) + 1 == HOLD_CYCLES)
      state_n = RUN;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ASSERT;
      chain    <= '0;
      hcnt     <= '0;
      SYNC_RST <= 1'b0;
      RST_DONE <= 1'b0;
      RST_CNT  <= '0;
    end else begin
      state    <= state_n;
      chain    <= accept ? '0 : {chain[NUM_STAGES-2:0], 1'b1};
      hcnt     <= state == HOLD ? hcnt + 1'b1 : '0;
      SYNC_RST <= state_n == RUN;
      RST_DONE <= state_n == RUN && state != RUN;
      RST_CNT  <= accept && !(&RST_CNT) ? RST_CNT + 1'b1 : RST_CNT;
    end
  end
endmodule

// File: tb/tb_rst_sync_stretch.sv
// tb_rst_sync_stretch: checks three configurations against an edge-counting model
module tb_rst_sync_stretch;
  logic CLK, RST, SW_RST_REQ;
  logic sync0, sync1, sync2, done0, done1, done2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  int checks = 0, errors = 0;
  localparam int LEN[3]  = '{6, 6, 3};
  localparam int MAXC[3] = '{255, 3, 255};
  int k[3], mcnt[3];

  rst_sync_stretch u0 (.CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .SYNC_RST(sync0), .RST_DONE(done0), .RST_CNT(cnt0));
  rst_sync_stretch #(.CNT_WIDTH(2)) u1 (.CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .SYNC_RST(sync1), .RST_DONE(done1), .RST_CNT(cnt1));
  rst_sync_stretch #(.NUM_STAGES(3), .HOLD_CYCLES(0)) u2 (.CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .SYNC_RST(sync2), .RST_DONE(done2), .RST_CNT(cnt2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // k = rising edges with RST high since the last reset event (capped at LEN+1)
  always @(posedge CLK or negedge RST) begin
    for (int i = 0; i < 3; i++) begin
      if (!RST) begin
        k[i]    <= 0;
        mcnt[i] <= 0;
      end else if (k[i] >= LEN[i] && SW_RST_REQ) begin
        k[i]    <= 0;
        mcnt[i] <= mcnt[i] < MAXC[i] ? mcnt[i] + 1 : mcnt[i];
      end else if (k[i] <= LEN[i]) begin
        k[i] <= k[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int s[3], d[3], c[3];
    @(posedge CLK);
    #1;
    s = '{int'(sync0), int'(sync1), int'(sync2)};
    d = '{int'(done0), int'(done1), int'(done2)};
    c = '{int'(cnt0), int'(cnt1), int'(cnt2)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_sync%0d", i), s[i], int'(k[i] >= LEN[i]));
      chk($sformatf("model_done%0d", i), d[i], int'(k[i] == LEN[i]));
      chk($sformatf("model_cnt%0d", i), c[i], mcnt[i]);
    end
  endtask

  initial begin
    RST = 1'b0;
    SW_RST_REQ = 1'b0;
    #1;
    chk("por_sync", int'(sync0), 0);
    chk("por_done", int'(done0), 0);
    chk("por_cnt", int'(cnt0), 0);
    repeat (10) step();
    RST = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("rel_sync0_e%0d", e), int'(sync0), int'(e >= 6));
      chk($sformatf("rel_done0_e%0d", e), int'(done0), int'(e == 6));
      chk($sformatf("rel_sync2_e%0d", e), int'(sync2), int'(e >= 3));
      chk($sformatf("rel_done2_e%0d", e), int'(done2), int'(e == 3));
    end
    RST = 1'b0;
    step();
    step();
    RST = 1'b1;
    repeat (4) step();
    RST = 1'b0;
    #1;
    chk("abort_sync0", int'(sync0), 0);
    repeat (3) step();
    RST = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("rerel_sync0_e%0d", e), int'(sync0), int'(e >= 6));
    end
    RST = 1'b0;
    step();
    RST = 1'b1;
    step();
    step();
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    chk("sync_sw_ign_cnt", int'(cnt0), 0);
    repeat (3) step();
    chk("sync_sw_ign_sync", int'(sync0), 1);
    chk("sync_sw_ign_cnt2", int'(cnt0), 0);
    repeat (2) step();
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    chk("sw_low0", int'(sync0), 0);
    chk("sw_low2", int'(sync2), 0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("sw_sync0_e%0d", e), int'(sync0), int'(e >= 6));
    end
    chk("sw_done0", int'(done0), 1);
    chk("sw_cnt0", int'(cnt0), 1);
    for (int p = 0; p < 4; p++) begin
      SW_RST_REQ = 1'b1;
      step();
      SW_RST_REQ = 1'b0;
      chk($sformatf("sat_cnt1_p%0d", p), int'(cnt1), p < 2 ? p + 2 : 3);
      repeat (7) step();
    end
    chk("sat_cnt0", int'(cnt0), 5);
    SW_RST_REQ = 1'b1;
    repeat (30) step();
    SW_RST_REQ = 1'b0;
    repeat (8) step();
    #2 RST = 1'b0;
    #1;
    chk("glitch20_sync0", int'(sync0), 0);
    chk("glitch20_sync2", int'(sync2), 0);
    #19 RST = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("g20_sync2_e%0d", e), int'(sync2), int'(e >= 3));
      chk($sformatf("g20_done2_e%0d", e), int'(done2), int'(e == 3));
    end
    chk("g20_cnt0", int'(cnt0), 0);
    repeat (4) step();
    #2 RST = 1'b0;
    #1;
    chk("short_glitch_sync0", int'(sync0), 0);
    #1 RST = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("sg_sync0_e%0d", e), int'(sync0), int'(e >= 6));
    end
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
